// File: rtl/hd63701_sci_pkg.sv
// HD63701 on-chip serial interface: shared definitions.
// Register map, TRCSR bit positions, SS rates and FSM encodings.
package hd63701_sci_pkg;

    localparam logic [1:0] A_RMCR  = 2'd0;
    localparam logic [1:0] A_TRCSR = 2'd1;
    localparam logic [1:0] A_RDR   = 2'd2;
    localparam logic [1:0] A_TDR   = 2'd3;

    localparam int B_RDRF = 7;
    localparam int B_ORFE = 6;
    localparam int B_TDRE = 5;
    localparam int B_RIE  = 4;
    localparam int B_RE   = 3;
    localparam int B_TIE  = 2;
    localparam int B_TE   = 1;
    localparam int B_WU   = 0;

    localparam int SS_DIV0 = 16;
    localparam int SS_DIV1 = 128;
    localparam int SS_DIV2 = 1024;
    localparam int SS_DIV3 = 4096;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } sci_state_e;

    // Eight subticks make one bit period.
    function automatic logic [11:0] ss_subtick(input logic [1:0] ss);
        logic [11:0] v;
        v = 12'(SS_DIV0 / 8);
        unique case (ss)
            2'd0: v = 12'(SS_DIV0 / 8);
            2'd1: v = 12'(SS_DIV1 / 8);
            2'd2: v = 12'(SS_DIV2 / 8);
            2'd3: v = 12'(SS_DIV3 / 8);
        endcase
        return v;
    endfunction

endpackage

// File: rtl/hd63701_sci_if.sv
// CPU register bus between the core and the SCI block.
// DOUT is combinational from the SCI registers.
interface hd63701_sci_if;
    logic       cs;
    logic [1:0] a;
    logic       rw;
    logic [7:0] di;
    logic [7:0] dout;

    modport master (
        output cs,
        output a,
        output rw,
        output di,
        input  dout
    );

    modport slave (
        input  cs,
        input  a,
        input  rw,
        input  di,
        output dout
    );
endinterface

// File: rtl/hd63701_sci_rx.sv
// SCI receiver: RXD synchronizer, receive FSM and shifter.
// Runs its own subtick divider so each frame is phased to its start edge.
module hd63701_sci_rx
    import hd63701_sci_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_rxd,
    input  logic        i_re,
    input  logic [11:0] i_lim,
    output logic        o_done,
    output logic        o_ok,
    output logic [7:0]  o_byte
);

    logic        r_s1;
    logic        r_s2;
    logic        r_prev;
    sci_state_e  r_st;
    sci_state_e  w_nxt;
    logic [11:0] r_pre;
    logic [2:0]  r_sub;
    logic [2:0]  r_bit;
    logic [7:0]  r_sh;
    logic        w_fall;
    logic        w_tick;
    logic        w_smp;
    logic        w_end;
    logic        w_go;

    assign w_fall = r_prev & ~r_s2;
    assign w_tick = (r_pre == i_lim - 12'd1);
    assign w_smp  = w_tick & (r_sub == 3'd3);
    assign w_end  = w_tick & (r_sub == 3'd7);

    always_comb begin
        w_nxt = r_st;
        w_go  = 1'b0;
        if (!i_re) begin
            w_nxt = ST_IDLE;
        end else begin
            unique case (r_st)
                ST_IDLE: begin
                    if (w_fall) begin
                        w_nxt = ST_START;
                        w_go  = 1'b1;
                    end
                end
                ST_START: begin
                    if (w_smp && r_s2)
                        w_nxt = ST_IDLE;
                    else if (w_end)
                        w_nxt = ST_DATA;
                end
                ST_DATA: begin
                    if (w_end && (r_bit == 3'd7))
                        w_nxt = ST_STOP;
                end
                ST_STOP: begin
                    if (w_smp)
                        w_nxt = ST_IDLE;
                end
                default: w_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1   <= 1'b1;
            r_s2   <= 1'b1;
            r_prev <= 1'b1;
            r_st   <= ST_IDLE;
        end else begin
            r_s1   <= i_rxd;
            r_s2   <= r_s1;
            r_prev <= r_s2;
            r_st   <= w_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pre <= '0;
            r_sub <= '0;
            r_bit <= '0;
            r_sh  <= '0;
        end else if (w_go) begin
            r_pre <= '0;
            r_sub <= '0;
            r_bit <= '0;
        end else begin
            r_pre <= w_tick ? 12'd0 : r_pre + 12'd1;
            if (w_tick)
                r_sub <= r_sub + 3'd1;
            if (r_st == ST_DATA) begin
                if (w_smp)
                    r_sh <= {r_s2, r_sh[7:1]};
                if (w_end)
                    r_bit <= r_bit + 3'd1;
            end
        end
    end

    assign o_done = i_re & (r_st == ST_STOP) & w_smp;
    assign o_ok   = r_s2;
    assign o_byte = r_sh;

endmodule

// File: rtl/hd63701_sci.sv
// HD63701 SCI top: register file, baud prescaler and transmitter.
// The receiver lives in hd63701_sci_rx.
module hd63701_sci
    import hd63701_sci_pkg::*;
(
    input  logic          i_clk,
    input  logic          i_rst_n,
    hd63701_sci_if.slave  bus,
    input  logic          i_rxd,
    output logic          o_txd,
    output logic          o_irq
);

    logic [1:0]  r_ss;
    logic        r_rie;
    logic        r_re;
    logic        r_tie;
    logic        r_te;
    logic        r_tdre;
    logic        r_rdrf;
    logic        r_orfe;
    logic [7:0]  r_rdr;
    logic [7:0]  r_tdr;
    logic        r_arm_tx;
    logic        r_arm_rx;
    logic        r_irq;
    logic [11:0] r_pre;

    sci_state_e  r_tx_st;
    sci_state_e  w_tx_nxt;
    logic [2:0]  r_tx_sub;
    logic [2:0]  r_tx_bit;
    logic [7:0]  r_tx_sh;
    logic        r_txd;
    logic        w_txd_nxt;
    logic        w_tx_load;
    logic        w_tx_bend;

    logic        w_rd;
    logic        w_wr;
    logic        w_rd_trcsr;
    logic        w_rd_rdr;
    logic        w_wr_rmcr;
    logic        w_wr_trcsr;
    logic        w_wr_tdr;
    logic        w_rx_clr;
    logic        w_rdrf_eff;
    logic [11:0] w_lim;
    logic        w_tick;
    logic [7:0]  w_trcsr;

    logic        w_rx_done;
    logic        w_rx_ok;
    logic [7:0]  w_rx_byte;

    assign w_rd       = bus.cs & bus.rw;
    assign w_wr       = bus.cs & ~bus.rw;
    assign w_rd_trcsr = w_rd & (bus.a == A_TRCSR);
    assign w_rd_rdr   = w_rd & (bus.a == A_RDR);
    assign w_wr_rmcr  = w_wr & (bus.a == A_RMCR);
    assign w_wr_trcsr = w_wr & (bus.a == A_TRCSR);
    assign w_wr_tdr   = w_wr & (bus.a == A_TDR);
    assign w_rx_clr   = w_rd_rdr & r_arm_rx;
    assign w_rdrf_eff = r_rdrf & ~w_rx_clr;

    always_comb begin
        w_trcsr         = '0;
        w_trcsr[B_RDRF] = r_rdrf;
        w_trcsr[B_ORFE] = r_orfe;
        w_trcsr[B_TDRE] = r_tdre;
        w_trcsr[B_RIE]  = r_rie;
        w_trcsr[B_RE]   = r_re;
        w_trcsr[B_TIE]  = r_tie;
        w_trcsr[B_TE]   = r_te;
        w_trcsr[B_WU]   = 1'b0;
    end

    always_comb begin
        bus.dout = '0;
        if (bus.cs) begin
            unique case (bus.a)
                A_RMCR:  bus.dout = {6'd0, r_ss};
                A_TRCSR: bus.dout = w_trcsr;
                A_RDR:   bus.dout = r_rdr;
                A_TDR:   bus.dout = r_tdr;
            endcase
        end
    end

    assign w_lim  = ss_subtick(r_ss);
    assign w_tick = (r_pre == w_lim - 12'd1);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_pre <= '0;
        else if (w_wr_rmcr || w_tick)
            r_pre <= '0;
        else
            r_pre <= r_pre + 12'd1;
    end

    assign w_tx_bend = w_tick & (r_tx_sub == 3'd7);

    always_comb begin
        w_tx_nxt  = r_tx_st;
        w_tx_load = 1'b0;
        unique case (r_tx_st)
            ST_IDLE: begin
                if (w_tick && r_te && !r_tdre) begin
                    w_tx_nxt  = ST_START;
                    w_tx_load = 1'b1;
                end
            end
            ST_START: begin
                if (w_tx_bend)
                    w_tx_nxt = ST_DATA;
            end
            ST_DATA: begin
                if (w_tx_bend && (r_tx_bit == 3'd7))
                    w_tx_nxt = ST_STOP;
            end
            ST_STOP: begin
                if (w_tx_bend) begin
                    if (r_te && !r_tdre) begin
                        w_tx_nxt  = ST_START;
                        w_tx_load = 1'b1;
                    end else begin
                        w_tx_nxt = ST_IDLE;
                    end
                end
            end
            default: w_tx_nxt = ST_IDLE;
        endcase
    end

    // TXD is registered off the next state so it never glitches.
    always_comb begin
        w_txd_nxt = 1'b1;
        if (w_tx_nxt == ST_START)
            w_txd_nxt = 1'b0;
        else if (w_tx_nxt == ST_DATA)
            w_txd_nxt = (r_tx_st == ST_DATA && w_tx_bend) ?
                        r_tx_sh[1] : r_tx_sh[0];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tx_st  <= ST_IDLE;
            r_tx_sub <= '0;
            r_tx_bit <= '0;
            r_tx_sh  <= '0;
            r_txd    <= 1'b1;
        end else begin
            r_tx_st <= w_tx_nxt;
            r_txd   <= w_txd_nxt;
            if (w_tx_load) begin
                r_tx_sh  <= r_tdr;
                r_tx_sub <= '0;
                r_tx_bit <= '0;
            end else if (w_tick && r_tx_st != ST_IDLE) begin
                r_tx_sub <= r_tx_sub + 3'd1;
                if (r_tx_st == ST_DATA && r_tx_sub == 3'd7) begin
                    r_tx_sh  <= r_tx_sh >> 1;
                    r_tx_bit <= r_tx_bit + 3'd1;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ss     <= '0;
            r_rie    <= 1'b0;
            r_re     <= 1'b0;
            r_tie    <= 1'b0;
            r_te     <= 1'b0;
            r_tdr    <= '0;
            r_tdre   <= 1'b1;
            r_arm_tx <= 1'b0;
            r_arm_rx <= 1'b0;
        end else begin
            if (bus.cs) begin
                r_arm_tx <= w_rd_trcsr & r_tdre;
                r_arm_rx <= w_rd_trcsr & (r_rdrf | r_orfe);
            end
            if (w_wr_rmcr)
                r_ss <= bus.di[1:0];
            if (w_wr_trcsr)
                {r_rie, r_re, r_tie, r_te} <= bus.di[4:1];
            if (w_wr_tdr)
                r_tdr <= bus.di;
            if (w_tx_load)
                r_tdre <= 1'b1;
            else if (w_wr_tdr && r_arm_tx)
                r_tdre <= 1'b0;
        end
    end

    // A byte arriving while the CPU clears RDRF is kept, not an overrun.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rdrf <= 1'b0;
            r_orfe <= 1'b0;
            r_rdr  <= '0;
        end else begin
            if (w_rx_clr) begin
                r_rdrf <= 1'b0;
                r_orfe <= 1'b0;
            end
            if (w_rx_done) begin
                if (w_rx_ok && !w_rdrf_eff) begin
                    r_rdr  <= w_rx_byte;
                    r_rdrf <= 1'b1;
                end else begin
                    r_orfe <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_irq <= 1'b0;
        else
            r_irq <= (r_rie & (r_rdrf | r_orfe)) | (r_tie & r_tdre);
    end

    hd63701_sci_rx u_rx (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_rxd   (i_rxd),
        .i_re    (r_re),
        .i_lim   (w_lim),
        .o_done  (w_rx_done),
        .o_ok    (w_rx_ok),
        .o_byte  (w_rx_byte)
    );

    assign o_txd = r_txd;
    assign o_irq = r_irq;

endmodule

// File: tb/tb_hd63701_sci.sv
// Directed bench for hd63701_sci at SS=01 (128 CLK per bit).
// Each task drives one scenario and checks against hand-computed values.
module tb_hd63701_sci;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic rxd   = 1'b1;
    logic txd;
    logic irq;
    int   n_vec = 0;
    int   n_bad = 0;

    hd63701_sci_if bus();

    hd63701_sci dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus),
        .i_rxd   (rxd),
        .o_txd   (txd),
        .o_irq   (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_rd(input logic [1:0] a, output logic [7:0] d);
        @(negedge clk);
        bus.cs = 1'b1;
        bus.a  = a;
        bus.rw = 1'b1;
        #1 d = bus.dout;
        @(negedge clk);
        bus.cs = 1'b0;
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [7:0] v);
        @(negedge clk);
        bus.cs = 1'b1;
        bus.a  = a;
        bus.rw = 1'b0;
        bus.di = v;
        @(negedge clk);
        bus.cs = 1'b0;
        bus.rw = 1'b1;
    endtask

    task automatic send_bit(input logic b);
        rxd = b;
        repeat (128) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] v, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++)
            send_bit(v[i]);
        send_bit(stop);
        rxd = 1'b1;
    endtask

    task automatic test_reset();
        logic [7:0] d;
        bus.cs = 1'b0;
        bus.a  = 2'd0;
        bus.rw = 1'b1;
        bus.di = 8'h00;
        rst_n  = 1'b0;
        idle(3);
        rst_n = 1'b1;
        idle(2);
        n_vec++;
        if (txd !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_txd got %b exp 1", txd);
        end
        n_vec++;
        if (irq !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_irq got %b exp 0", irq);
        end
        bus_rd(2'd1, d);
        n_vec++;
        if (d !== 8'h20) begin
            n_bad++;
            $display("FAIL reset_trcsr got %h exp 20", d);
        end
        bus_rd(2'd0, d);
        n_vec++;
        if (d !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_rmcr got %h exp 00", d);
        end
        bus_rd(2'd2, d);
        n_vec++;
        if (d !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_rdr got %h exp 00", d);
        end
        bus_rd(2'd3, d);
        n_vec++;
        if (d !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_tdr got %h exp 00", d);
        end
    endtask

    task automatic test_no_arm();
        logic [7:0] d;
        int lows;
        bus_wr(2'd0, 8'hFD);
        bus_rd(2'd0, d);
        n_vec++;
        if (d !== 8'h01) begin
            n_bad++;
            $display("FAIL rmcr_mask got %h exp 01", d);
        end
        bus_wr(2'd1, 8'h03);
        bus_wr(2'd3, 8'h5A);
        lows = 0;
        repeat (400) begin
            @(negedge clk);
            if (txd !== 1'b1)
                lows++;
        end
        n_vec++;
        if (lows !== 0) begin
            n_bad++;
            $display("FAIL noarm_txd low cycles got %0d exp 0", lows);
        end
        bus_rd(2'd1, d);
        n_vec++;
        if (d !== 8'h22) begin
            n_bad++;
            $display("FAIL noarm_trcsr got %h exp 22", d);
        end
        bus_rd(2'd3, d);
        n_vec++;
        if (d !== 8'h5A) begin
            n_bad++;
            $display("FAIL noarm_tdr got %h exp 5a", d);
        end
    endtask

    task automatic test_tx();
        logic [7:0] d;
        logic [7:0] v;
        int t;
        v = 8'hA5;
        bus_rd(2'd1, d);
        bus_wr(2'd3, v);
        t = 0;
        while (txd === 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        n_vec++;
        if (t >= 100) begin
            n_bad++;
            $display("FAIL tx_start_timeout got %0d cycles exp <100", t);
        end
        idle(64);
        n_vec++;
        if (txd !== 1'b0) begin
            n_bad++;
            $display("FAIL tx_startbit got %b exp 0", txd);
        end
        bus_rd(2'd1, d);
        n_vec++;
        if (d !== 8'h22) begin
            n_bad++;
            $display("FAIL tx_tdre_set got %h exp 22", d);
        end
        idle(126);
        for (int i = 0; i < 8; i++) begin
            n_vec++;
            if (txd !== v[i]) begin
                n_bad++;
                $display("FAIL tx_bit%0d got %b exp %b", i, txd, v[i]);
            end
            idle(128);
        end
        n_vec++;
        if (txd !== 1'b1) begin
            n_bad++;
            $display("FAIL tx_stopbit got %b exp 1", txd);
        end
        idle(256);
        n_vec++;
        if (txd !== 1'b1) begin
            n_bad++;
            $display("FAIL tx_idle got %b exp 1", txd);
        end
    endtask

    task automatic test_rx();
        logic [7:0] d;
        bus_wr(2'd1, 8'h18);
        idle(10);
        send_frame(8'h3C, 1'b1);
        idle(4);
        n_vec++;
        if (irq !== 1'b1) begin
            n_bad++;
            $display("FAIL rx_irq_set got %b exp 1", irq);
        end
        bus_rd(2'd1, d);
        n_vec++;
        if (d !== 8'hB8) begin
            n_bad++;
            $display("FAIL rx_trcsr got %h exp b8", d);
        end
        bus_rd(2'd2, d);
        n_vec++;
        if (d !== 8'h3C) begin
            n_bad++;
            $display("FAIL rx_rdr got %h exp 3c", d);
        end
        idle(3);
        n_vec++;
        if (irq !== 1'b0) begin
            n_bad++;
            $display("FAIL rx_irq_clr got %b exp 0", irq);
        end
    endtask

    task automatic test_overrun();
        logic [7:0] d;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        idle(4);
        bus_rd(2'd1, d);
        n_vec++;
        if (d !== 8'hF8) begin
            n_bad++;
            $display("FAIL ovr_trcsr got %h exp f8", d);
        end
        bus_rd(2'd2, d);
        n_vec++;
        if (d !== 8'h11) begin
            n_bad++;
            $display("FAIL ovr_rdr got %h exp 11", d);
        end
        bus_rd(2'd1, d);
        n_vec++;
        if (d !== 8'h38) begin
            n_bad++;
            $display("FAIL ovr_clr got %h exp 38", d);
        end
    endtask

    task automatic test_framing();
        logic [7:0] d;
        send_frame(8'h55, 1'b0);
        idle(4);
        bus_rd(2'd1, d);
        n_vec++;
        if (d !== 8'h78) begin
            n_bad++;
            $display("FAIL fe_trcsr got %h exp 78", d);
        end
        bus_rd(2'd2, d);
        n_vec++;
        if (d !== 8'h11) begin
            n_bad++;
            $display("FAIL fe_rdr got %h exp 11", d);
        end
        bus_rd(2'd1, d);
        n_vec++;
        if (d !== 8'h38) begin
            n_bad++;
            $display("FAIL fe_clr got %h exp 38", d);
        end
    endtask

    task automatic test_glitch();
        logic [7:0] d;
        rxd = 1'b0;
        idle(30);
        rxd = 1'b1;
        idle(300);
        bus_rd(2'd1, d);
        n_vec++;
        if (d !== 8'h38) begin
            n_bad++;
            $display("FAIL glitch_trcsr got %h exp 38", d);
        end
        send_frame(8'h7E, 1'b1);
        idle(4);
        bus_rd(2'd1, d);
        bus_rd(2'd2, d);
        n_vec++;
        if (d !== 8'h7E) begin
            n_bad++;
            $display("FAIL glitch_next_rdr got %h exp 7e", d);
        end
    endtask

    task automatic test_re_abort();
        logic [7:0] d;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        bus_wr(2'd1, 8'h10);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        rxd = 1'b1;
        idle(20);
        bus_rd(2'd1, d);
        n_vec++;
        if (d !== 8'h30) begin
            n_bad++;
            $display("FAIL abort_trcsr got %h exp 30", d);
        end
        n_vec++;
        if (irq !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_irq got %b exp 0", irq);
        end
        bus_wr(2'd1, 8'h18);
        idle(10);
        send_frame(8'h42, 1'b1);
        idle(4);
        bus_rd(2'd1, d);
        n_vec++;
        if (d !== 8'hB8) begin
            n_bad++;
            $display("FAIL abort_next_trcsr got %h exp b8", d);
        end
        bus_rd(2'd2, d);
        n_vec++;
        if (d !== 8'h42) begin
            n_bad++;
            $display("FAIL abort_next_rdr got %h exp 42", d);
        end
    endtask

    task automatic test_tie_irq();
        bus_wr(2'd1, 8'h04);
        idle(2);
        n_vec++;
        if (irq !== 1'b1) begin
            n_bad++;
            $display("FAIL tie_irq_on got %b exp 1", irq);
        end
        bus_wr(2'd1, 8'h00);
        idle(2);
        n_vec++;
        if (irq !== 1'b0) begin
            n_bad++;
            $display("FAIL tie_irq_off got %b exp 0", irq);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        int t;
        bus_wr(2'd1, 8'h02);
        bus_rd(2'd1, d);
        bus_wr(2'd3, 8'hC3);
        t = 0;
        while (txd === 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        idle(40);
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (txd !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_txd_async got %b exp 1", txd);
        end
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        bus_rd(2'd1, d);
        n_vec++;
        if (d !== 8'h20) begin
            n_bad++;
            $display("FAIL rst_mid_trcsr got %h exp 20", d);
        end
    endtask

    initial begin
        test_reset();
        test_no_arm();
        test_tx();
        test_rx();
        test_overrun();
        test_framing();
        test_glitch();
        test_re_abort();
        test_tie_irq();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
